debug_arbiter: RTL and testbench
================================

# debug_arbiter

Shares the single per-PE simulation debug sink (UART, scheduling, pipe, traffic and safe-record writes) between several write sources inside a PE. Each source has its own small FIFO, and a round-robin arbiter issues at most one write per cycle to the sink. The sink has no back-pressure, so the arbiter throttles sources only through their FIFO ready signals. The arbiter also keeps multi-word safe records together: once a source starts a record, no other source's writes reach the sink until that record completes.

## Interface
Parameters:
- N_REQ, 4, number of write sources (≥2)
- FIFO_DEPTH, 4, entries per source FIFO (power of two, ≥2)
- LOCK_TIMEOUT, 256, maximum cycles a record lock may stall without issuing

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_en_i  in  N_REQ  per-source access strobe
- req_we_i  in  N_REQ  per-source write enable
- req_addr_i  in  N_REQ×24  per-source address
- req_data_i  in  N_REQ×32  per-source write data
- req_ready_o  out  N_REQ  FIFO can accept a write
- dbg_en_o  out  1  sink strobe
- dbg_we_o  out  1  sink write enable, always equal to dbg_en_o
- dbg_addr_o  out  24  sink address
- dbg_data_o  out  32  sink data
- lock_o  out  1  record lock held
- lock_owner_o  out  $clog2(N_REQ)  index of the source holding the lock
- timeout_o  out  1  one-cycle pulse when a lock is forcibly released

## Operation
- Accept: source i pushes {addr, data} when req_en_i[i] && req_we_i[i] && req_ready_o[i].
- Reads: accesses with req_en_i && !req_we_i are acknowledged, because ready is independent of we, and then discarded.
- req_ready_o[i] = !full[i], taken from the registered count. A FIFO that is full is not ready, even in a cycle where it pops.
- States: ARB and LOCKED.
  - ARB: round-robin over the non-empty FIFOs, searching from last_grant+1 upward with wrap. The winner's head is popped and registered onto the sink outputs, and last_grant is set to the winner.
  - If the popped address is in the record window 0x50, 0x54, 0x58 or 0x5C: go to LOCKED with owner = winner.
  - LOCKED: only the owner's FIFO is considered. Other FIFOs keep filling but never pop.
  - If the owner pops address 0x60 (record commit): go to ARB after that pop.
  - If the owner pops another window address: stay in LOCKED and clear the timeout counter.
  - Non-window addresses popped by the owner: issued normally, state unchanged.
  - Timeout counter: counts each LOCKED cycle with no pop. When it reaches LOCKE_TIMEOUT, the block returns to ARB, pulses timeout_o, and clears the counter.
- Idle cycle (nothing eligible): dbg_en_o = 0. dbg_addr_o and dbg_data_o hold their last values.
- Reset: clears FIFO pointers and counts, state = ARB, last_grant = N_REQ-1 (so source 0 is searched first), timeout counter = 0. All outputs are 0 except req_ready_o, which is all ones.
- Reset asserted mid-record: the record is lost; no partial recovery.

## Timing
- A write accepted at edge k enters the FIFO at edge k. It is eligible in the following cycle, popped at edge k+1, and visible on dbg_* from edge k+1. Minimum latency is therefore 2 cycles from presenting the write to the sink strobe.
- Throughput: one sink write per cycle in total across all sources.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.
- ARB→LOCKED and LOCKED→ARB take effect at the edge of the triggering pop. A different source may win in the very next cycle.
- Lock timeout:
  - The counter width is $clog2(LOCK_TIMEOUT+1).
  - The release edge is the LOCK_TIMEOUT-th consecutive stalled LOCKED cycle.
  - timeout_o is high for exactly the cycle after that edge.
- lock_o and lock_owner_o are registered state. lock_owner_o is 0 while in ARB.

## Configuration
- DEBUG_ARB_TIMEOUT_EN:
  - Defined: the timeout counter and timeout_o logic are present as described.
  - Undefined: the lock is held until a 0x60 write pops, indefinitely if necessary. timeout_o is tied to 0 and no counter is instantiated.

## Structure
- Shared package DebugArbPkg holds:
  - typedef dbg_wr_t (24-bit addr, 32-bit data)
  - the record-window constants SAFE_FIRST = 24'h50, SAFE_LAST = 24'h5C, SAFE_COMMIT = 24'h60
  - the enum arb_state_t {ARB, LOCKED}
- One sub-module, debug_arb_fifo: a synchronous FIFO of dbg_wr_t with FIFO_DEPTH entries, providing full, empty and count, with asynchronous active-low reset. It is instantiated N_REQ times.

## Test plan
- Single source: source 0 writes addr 0x00, data 0x41 at cycle 10 → dbg_en_o=1, addr 0x00, data 0x41 in cycle 12; all other cycles have dbg_en_o=0.
- Round-robin: all 4 sources each push one write (addr 0x00, data=i) in the same cycle after reset → sink order is data 0,1,2,3 on consecutive cycles.
- Record lock: source 1 pushes 0x50, 0x54, 0x58, 0x5C, 0x60 while source 2 streams addr 0x00 writes → the five record writes reach the sink contiguously, with no 0x00 writes between 0x50 and 0x60.
- Backpressure: source 0 pushes 6 writes back-to-back while locked out by source 1's record → req_ready_o[0] drops after 4 accepts; all 6 writes arrive later in order.
- Timeout (macro defined, LOCK_TIMEOUT=8): source 3 pushes only 0x50 → timeout_o pulses 8 stalled cycles after the 0x50 issue, and the other sources resume.
- Reset mid-record: assert rst_ni low while LOCKED → all outputs return to reset values immediately, and the FIFOs are empty after release.

Source files
------------

// File: rtl/debug_arbiter_pkg.sv
// Shared types and constants for the debug-sink arbiter.
// Safe records use the address window 0x50..0x5C and are committed by a write to 0x60.
package DebugArbPkg;

    localparam logic [23:0] SAFE_FIRST  = 24'h50;
    localparam logic [23:0] SAFE_LAST   = 24'h5C;
    localparam logic [23:0] SAFE_COMMIT = 24'h60;

    typedef struct packed {
        logic [23:0] addr;
        logic [31:0] data;
    } dbg_wr_t;

    typedef enum logic {
        ARB,
        LOCKED
    } arb_state_t;

    // True for the four word addresses that open or extend a safe record.
    function automatic logic in_safe_window(input logic [23:0] addr);
        return (addr >= SAFE_FIRST) && (addr <= SAFE_LAST) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/debug_arbiter_fifo.sv
// Per-source write FIFO for the debug arbiter.
// The head entry is readable combinationally so a write pushed at one edge can
// be popped at the very next edge. Pushes into a full FIFO and pops from an
// empty FIFO are ignored.
module debug_arb_fifo
    import DebugArbPkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push,
    input  logic          pop,
    input  dbg_wr_t       wdata,
    output dbg_wr_t       rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    dbg_wr_t       mem_reg [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rdata   = mem_reg[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents need no reset because the count guards every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= wdata;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

endmodule

// File: rtl/debug_arbiter.sv
// Round-robin arbiter sharing the per-PE debug sink between N_REQ write sources.
// Each source buffers into its own FIFO; one write per cycle reaches the sink.
// Safe records (0x50..0x5C ... 0x60) from one source are kept contiguous by a lock.
// Optional macro DEBUG_ARB_TIMEOUT_EN adds a stall counter that force-releases the
// lock after LOCK_TIMEOUT stalled cycles and pulses timeout_o.
module debug_arbiter
    import DebugArbPkg::*;
#(
    parameter int  N_REQ        = 4,
    parameter int  FIFO_DEPTH   = 4,
    parameter int  LOCK_TIMEOUT = 256,
    localparam int IW           = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_REQ-1:0]       req_en_i,
    input  logic [N_REQ-1:0]       req_we_i,
    input  logic [N_REQ-1:0][23:0] req_addr_i,
    input  logic [N_REQ-1:0][31:0] req_data_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic                   dbg_en_o,
    output logic                   dbg_we_o,
    output logic [23:0]            dbg_addr_o,
    output logic [31:0]            dbg_data_o,
    output logic                   lock_o,
    output logic [IW-1:0]          lock_owner_o,
    output logic                   timeout_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    dbg_wr_t          head [N_REQ];
    logic [CW-1:0]    fifo_count [N_REQ];
    logic [N_REQ-1:0] fifo_full;
    logic [N_REQ-1:0] fifo_empty;
    logic [N_REQ-1:0] push;
    logic [N_REQ-1:0] pop;
    logic [N_REQ-1:0] eligible;
    logic             grant_valid;
    logic [IW-1:0]    grant_idx;
    logic [IW-1:0]    cand_idx;
    dbg_wr_t          grant_wr;
    logic             lock_release;

    arb_state_t       state_reg;
    logic [IW-1:0]    owner_reg;
    logic [IW-1:0]    last_grant_reg;
    logic             dbg_en_reg;
    logic [23:0]      dbg_addr_reg;
    logic [31:0]      dbg_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_src
            dbg_wr_t wr_in;
            // Reads are acknowledged by ready but never enter the FIFO.
            assign wr_in           = {req_addr_i[gi], req_data_i[gi]};
            assign push[gi]        = req_en_i[gi] && req_we_i[gi] && !fifo_full[gi];
            assign req_ready_o[gi] = (fifo_count[gi] != CW'(FIFO_DEPTH));

            debug_arb_fifo #(
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk_i  (clk_i),
                .rst_ni (rst_ni),
                .push   (push[gi]),
                .pop    (pop[gi]),
                .wdata  (wr_in),
                .rdata  (head[gi]),
                .full   (fifo_full[gi]),
                .empty  (fifo_empty[gi]),
                .count  (fifo_count[gi])
            );
        end
    endgenerate

    // Pick the next source: nearest non-empty FIFO after last_grant, or only the owner while locked.
    always_comb begin
        eligible = ~fifo_empty;
        if (state_reg == LOCKED) begin
            eligible = eligible & (N_REQ'(1) << owner_reg);
        end
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        // Scan from the farthest offset down so the nearest eligible source wins.
        for (int off = N_REQ; off >= 1; off--) begin
            cand_idx = IW'((int'(last_grant_reg) + off) % N_REQ);
            if (eligible[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        pop = grant_valid ? (N_REQ'(1) << grant_idx) : '0;
    end

    assign grant_wr = head[grant_idx];

`ifdef DEBUG_ARB_TIMEOUT_EN
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);

    logic [TW-1:0] stall_cnt_reg;
    logic          timeout_reg;

    assign lock_release = (state_reg == LOCKED) && !grant_valid &&
                          (stall_cnt_reg == TW'(LOCK_TIMEOUT - 1));
    assign timeout_o    = timeout_reg;

    // Count consecutive stalled locked cycles; any pop or leaving the lock restarts the count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_reg <= '0;
            timeout_reg   <= 1'b0;
        end else begin
            timeout_reg <= lock_release;
            if (state_reg != LOCKED || grant_valid || lock_release) begin
                stall_cnt_reg <= '0;
            end else begin
                stall_cnt_reg <= stall_cnt_reg + TW'(1);
            end
        end
    end
`else
    // Without the timeout the lock is held until the owner commits; timeout_o stays low.
    assign lock_release = 1'b0;
    assign timeout_o    = (LOCK_TIMEOUT < 0);
`endif

    // Issue the granted write to the sink and track the record-lock state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= ARB;
            owner_reg      <= '0;
            last_grant_reg <= IW'(N_REQ - 1);
            dbg_en_reg     <= 1'b0;
            dbg_addr_reg   <= '0;
            dbg_data_reg   <= '0;
        end else begin
            dbg_en_reg <= grant_valid;
            if (grant_valid) begin
                dbg_addr_reg   <= grant_wr.addr;
                dbg_data_reg   <= grant_wr.data;
                last_grant_reg <= grant_idx;
                if (state_reg == ARB) begin
                    if (in_safe_window(grant_wr.addr)) begin
                        state_reg <= LOCKED;
                        owner_reg <= grant_idx;
                    end
                end else if (grant_wr.addr == SAFE_COMMIT) begin
                    state_reg <= ARB;
                    owner_reg <= '0;
                end
            end else if (lock_release) begin
                state_reg <= ARB;
                owner_reg <= '0;
            end
        end
    end

    assign dbg_en_o     = dbg_en_reg;
    assign dbg_we_o     = dbg_en_reg;
    assign dbg_addr_o   = dbg_addr_reg;
    assign dbg_data_o   = dbg_data_reg;
    assign lock_o       = (state_reg == LOCKED);
    assign lock_owner_o = owner_reg;

endmodule

// File: tb/tb_debug_arbiter.sv
// Testbench for debug_arbiter: a queue-based model of the sink-sharing rules is
// compared against the DUT on every falling edge, and directed scenarios pin
// the observed sink sequence to hand-computed values.
module tb_debug_arbiter;

    localparam int N = 4;
    localparam int D = 4;
    localparam int T = 8;

    logic             clk_i  = 1'b0;
    logic             rst_ni = 1'b0;
    logic [N-1:0]     req_en_i = '0;
    logic [N-1:0]     req_we_i = '0;
    logic [N-1:0][23:0] req_addr_i = '0;
    logic [N-1:0][31:0] req_data_i = '0;
    logic [N-1:0]     req_ready_o;
    logic             dbg_en_o;
    logic             dbg_we_o;
    logic [23:0]      dbg_addr_o;
    logic [31:0]      dbg_data_o;
    logic             lock_o;
    logic [1:0]       lock_owner_o;
    logic             timeout_o;

    always #5 clk_i = ~clk_i;

    debug_arbiter #(
        .N_REQ        (N),
        .FIFO_DEPTH   (D),
        .LOCK_TIMEOUT (T)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .req_en_i     (req_en_i),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_data_i   (req_data_i),
        .req_ready_o  (req_ready_o),
        .dbg_en_o     (dbg_en_o),
        .dbg_we_o     (dbg_we_o),
        .dbg_addr_o   (dbg_addr_o),
        .dbg_data_o   (dbg_data_o),
        .lock_o       (lock_o),
        .lock_owner_o (lock_owner_o),
        .timeout_o    (timeout_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- behavioural model ----------------
    logic [55:0] mq [N][$];
    bit          m_locked;
    int          m_owner;
    int          m_last;
    int          m_stall;
    bit          m_en;
    logic [23:0] m_addr;
    logic [31:0] m_data;
    bit          m_timeout;

    task automatic model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        m_locked  = 0;
        m_owner   = 0;
        m_last    = N - 1;
        m_stall   = 0;
        m_en      = 0;
        m_addr    = '0;
        m_data    = '0;
        m_timeout = 0;
    endtask

    task automatic model_step();
        bit          acc [N];
        int          pick;
        logic [55:0] w;
        pick = -1;
        for (int i = 0; i < N; i++)
            acc[i] = req_en_i[i] && req_we_i[i] && (mq[i].size() < D);
        if (m_locked) begin
            if (mq[m_owner].size() > 0) pick = m_owner;
        end else begin
            for (int j = 1; j <= N; j++) begin
                int c;
                c = (m_last + j) % N;
                if (pick < 0 && mq[c].size() > 0) pick = c;
            end
        end
        m_timeout = 0;
        if (pick >= 0) begin
            w      = mq[pick].pop_front();
            m_en   = 1;
            m_addr = w[55:32];
            m_data = w[31:0];
            m_last = pick;
            if (!m_locked) begin
                if (m_addr inside {24'h50, 24'h54, 24'h58, 24'h5C}) begin
                    m_locked = 1;
                    m_owner  = pick;
                    m_stall  = 0;
                end
            end else if (m_addr == 24'h60) begin
                m_locked = 0;
            end else begin
                m_stall = 0;
            end
        end else begin
            m_en = 0;
`ifdef DEBUG_ARB_TIMEOUT_EN
            if (m_locked) begin
                m_stall++;
                if (m_stall == T) begin
                    m_locked  = 0;
                    m_timeout = 1;
                    m_stall   = 0;
                end
            end
`endif
        end
        for (int i = 0; i < N; i++)
            if (acc[i]) mq[i].push_back({req_addr_i[i], req_data_i[i]});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk_i or negedge rst_ni);
            if (!rst_ni) model_reset();
            else model_step();
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
        end
    endtask

    logic [55:0] slog [$];
    int          scyc [$];
    int          tlog [$];

    function automatic logic [55:0] slog_at(input int i);
        return (i < slog.size()) ? slog[i] : 'x;
    endfunction

    function automatic int scyc_at(input int i);
        return (i < scyc.size()) ? scyc[i] : -1;
    endfunction

    // Every cycle: DUT outputs against the model; also log sink writes and timeout pulses.
    initial begin
        forever begin
            logic [N-1:0] exp_ready;
            @(negedge clk_i);
            for (int i = 0; i < N; i++) exp_ready[i] = (mq[i].size() < D);
            chk("dbg_en", dbg_en_o, m_en);
            chk("dbg_we", dbg_we_o, m_en);
            chk("dbg_addr", dbg_addr_o, m_addr);
            chk("dbg_data", dbg_data_o, m_data);
            chk("ready", req_ready_o, exp_ready);
            chk("lock", lock_o, m_locked);
            chk("owner", lock_owner_o, m_locked ? m_owner : 0);
            chk("timeout", timeout_o, m_timeout);
            if (rst_ni && dbg_en_o) begin
                slog.push_back({dbg_addr_o, dbg_data_o});
                scyc.push_back(cyc);
            end
            if (rst_ni && timeout_o) tlog.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk_i);
    endtask

    task automatic drive(input int s, input logic [23:0] a, input logic [31:0] d);
        req_en_i[s]   = 1'b1;
        req_we_i[s]   = 1'b1;
        req_addr_i[s] = a;
        req_data_i[s] = d;
    endtask

    task automatic clr(input int s);
        req_en_i[s] = 1'b0;
        req_we_i[s] = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        #2 rst_ni = 1'b0;
        req_en_i = '0;
        req_we_i = '0;
        tick();
        tick();
        #2 rst_ni = 1'b1;
        tick();
        slog.delete();
        scyc.delete();
        tlog.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int k;
        bit seen4;
        bit acc;

        // Reset state
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();
        chk("reset_ready", req_ready_o, 4'hF);
        chk("reset_en", dbg_en_o, 1'b0);
        chk("reset_lock", lock_o, 1'b0);

        // Single source; a concurrent read from source 1 must be dropped
        do_reset();
        repeat (5) tick();
        c0 = cyc;
        drive(0, 24'h00, 32'h41);
        req_en_i[1] = 1'b1;
        req_we_i[1] = 1'b0;
        req_addr_i[1] = 24'h08;
        tick();
        clr(0);
        clr(1);
        repeat (6) tick();
        chk("t1_count", slog.size(), 1);
        chk("t1_wr", slog_at(0), {24'h00, 32'h41});
        chk("t1_cycle", scyc_at(0), c0 + 2);

        // Round-robin after reset: sources 0..3 in order on consecutive cycles
        do_reset();
        for (int i = 0; i < N; i++) drive(i, 24'h00, 32'(i));
        tick();
        for (int i = 0; i < N; i++) clr(i);
        repeat (8) tick();
        chk("t2_count", slog.size(), 4);
        for (int i = 0; i < N; i++) begin
            chk("t2_data", slog_at(i), {24'h00, 32'(i)});
            chk("t2_cycle", scyc_at(i), scyc_at(0) + i);
        end

        // Record lock: source 1 record vs source 2 stream
        do_reset();
        for (int j = 0; j < 8; j++) begin
            if (j < 5) drive(1, 24'h50 + 24'(4 * j), 32'h100 + 32'(j));
            else clr(1);
            drive(2, 24'h00, 32'h200 + 32'(j));
            tick();
        end
        clr(1);
        clr(2);
        repeat (20) tick();
        chk("t3_count", slog.size(), 10);
        chk("t3_rec0", slog_at(0), {24'h50, 32'h100});
        chk("t3_rec1", slog_at(1), {24'h54, 32'h101});
        chk("t3_rec2", slog_at(2), {24'h58, 32'h102});
        chk("t3_rec3", slog_at(3), {24'h5C, 32'h103});
        chk("t3_rec4", slog_at(4), {24'h60, 32'h104});
        chk("t3_s2_first", slog_at(5), {24'h00, 32'h200});
        chk("t3_s2_last", slog_at(9), {24'h00, 32'h207});

        // Backpressure: source 0 blocked behind source 1's record
        do_reset();
        drive(1, 24'h50, 32'h150);
        tick();
        clr(1);
        k = 0;
        seen4 = 0;
        for (int t = 1; t <= 40; t++) begin
            if (k < 6) drive(0, 24'h10 + 24'(4 * k), 32'hA0 + 32'(k));
            else clr(0);
            if (t == 5) drive(1, 24'h60, 32'h160);
            else clr(1);
            if (k == 4 && !seen4) begin
                chk("t4_ready_after4", req_ready_o[0], 1'b0);
                seen4 = 1;
            end
            acc = (k < 6) && req_ready_o[0];
            tick();
            if (acc) k++;
        end
        clr(0);
        chk("t4_accepted", k, 6);
        chk("t4_count", slog.size(), 8);
        chk("t4_open", slog_at(0), {24'h50, 32'h150});
        chk("t4_commit", slog_at(1), {24'h60, 32'h160});
        for (int j = 0; j < 6; j++)
            chk("t4_order", slog_at(2 + j), {24'h10 + 24'(4 * j), 32'hA0 + 32'(j)});

        // Lock timeout: source 3 opens a record and never finishes it
        do_reset();
        c0 = cyc;
        drive(3, 24'h50, 32'h350);
        tick();
        clr(3);
        tick();
        tick();
        drive(0, 24'h04, 32'hB0);
        tick();
        clr(0);
        repeat (20) tick();
        chk("t5_open_cycle", scyc_at(0), c0 + 2);
`ifdef DEBUG_ARB_TIMEOUT_EN
        chk("t5_pulses", tlog.size(), 1);
        chk("t5_pulse_cycle", (tlog.size() > 0) ? tlog[0] : -1, c0 + 10);
        chk("t5_resume", slog_at(1), {24'h04, 32'hB0});
        chk("t5_resume_cycle", scyc_at(1), c0 + 11);
`else
        chk("t5_pulses", tlog.size(), 0);
        chk("t5_held", lock_o, 1'b1);
        chk("t5_owner", lock_owner_o, 2'd3);
        chk("t5_count", slog.size(), 1);
`endif

        // Reset asserted mid-record
        do_reset();
        drive(1, 24'h50, 32'h150);
        drive(2, 24'h00, 32'h250);
        tick();
        drive(1, 24'h54, 32'h151);
        clr(2);
        tick();
        clr(1);
        tick();
        chk("t6_locked", lock_o, 1'b1);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_en", dbg_en_o, 1'b0);
        chk("t6_addr", dbg_addr_o, 24'h0);
        chk("t6_data", dbg_data_o, 32'h0);
        chk("t6_lock", lock_o, 1'b0);
        chk("t6_owner", lock_owner_o, 2'd0);
        chk("t6_ready", req_ready_o, 4'hF);
        chk("t6_timeout", timeout_o, 1'b0);
        tick();
        tick();
        #2 rst_ni = 1'b1;
        slog.delete();
        scyc.delete();
        repeat (6) tick();
        chk("t6_empty", slog.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
